// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : Load/store responder for a word-wide synchronous SRAM. Handles
//            byte/half/word accesses, splits word-crossing misaligned
//            accesses into two word accesses, and sign/zero-extends loads.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit (
   input  logic        CLK,
   input  logic        RST,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  mem_sz,
   input  logic [2:0]  mem_sx,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        busy,
   output logic        done,
   output logic        sram_en,
   output logic        sram_we,
   output logic [29:0] sram_addr,
   output logic [3:0]  sram_be,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_S0   = 3'd1,
      ST_S1   = 3'd2,
      ST_L0   = 3'd3,
      ST_L1   = 3'd4,
      ST_LW   = 3'd5,
      ST_DONE = 3'd6
   } state_t;

   state_t      r_state;

   // Request context captured in IDLE
   logic [1:0]  r_sz;
   logic        r_zx;
   logic [1:0]  r_off;
   logic [29:0] r_word0;
   logic        r_cross;
   logic [3:0]  r_be_hi;
   logic [31:0] r_wd_hi;
   logic [31:0] r_w0;

   // Registered outputs
   logic [31:0] r_rdata;
   logic        r_done;
   logic        r_sram_en;
   logic        r_sram_we;
   logic [29:0] r_sram_addr;
   logic [3:0]  r_sram_be;
   logic [31:0] r_sram_wdata;

   // Request decode, evaluated on the live inputs in IDLE only
   logic [3:0]  w_mask;
   logic [7:0]  w_be8;
   logic [63:0] w_win;
   logic        w_cross_in;

   // Load assembly, evaluated on captured context and SRAM return data
   logic [31:0] w_lo;
   logic [31:0] w_hi;
   logic [63:0] w_cat;
   logic [31:0] w_load;
   logic [29:0] w_word1;
   logic        w_unused;

   // Size to byte-lane mask; code 11 behaves as a word access
   always_comb begin
      w_mask = 4'b1111;
      case (mem_sz)
         2'b00:   w_mask = 4'b0001;
         2'b01:   w_mask = 4'b0011;
         default: w_mask = 4'b1111;
      endcase
   end

   // Enables and write data laid out across a two-word window; the upper
   // nibble/word only becomes non-zero when the access spills into word1
   assign w_be8      = {4'b0000, w_mask} << addr[1:0];
   assign w_win      = {32'h0000_0000, wdata} << {addr[1:0], 3'b000};
   assign w_cross_in = |w_be8[7:4];

   // Word1 wraps modulo 2^30 by natural overflow of the 30-bit adder
   assign w_word1 = r_word0 + 30'd1;

   // For a split load the first word was parked in r_w0 and the second word
   // is arriving now; otherwise the only word is arriving now
   assign w_lo  = r_cross ? r_w0 : sram_rdata;
   assign w_hi  = r_cross ? sram_rdata : 32'h0000_0000;
   assign w_cat = {w_hi, w_lo} >> {r_off, 3'b000};

   // Trim to the access size and extend (r_zx set means zero-extend)
   always_comb begin
      w_load = w_cat[31:0];
      case (r_sz)
         2'b00:   w_load = {{24{~r_zx & w_cat[7]}},  w_cat[7:0]};
         2'b01:   w_load = {{16{~r_zx & w_cat[15]}}, w_cat[15:0]};
         default: w_load = w_cat[31:0];
      endcase
   end

   assign w_unused = ^{mem_sx[1:0], w_cat[63:32]};

   // Sequencer: each transition also registers the SRAM command for the
   // state being entered, so the SRAM port never sees a combinational req
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state      <= ST_IDLE;
         r_sz         <= 2'b00;
         r_zx         <= 1'b0;
         r_off        <= 2'b00;
         r_word0      <= '0;
         r_cross      <= 1'b0;
         r_be_hi      <= 4'h0;
         r_wd_hi      <= '0;
         r_w0         <= '0;
         r_rdata      <= '0;
         r_done       <= 1'b0;
         r_sram_en    <= 1'b0;
         r_sram_we    <= 1'b0;
         r_sram_addr  <= '0;
         r_sram_be    <= 4'h0;
         r_sram_wdata <= '0;
      end else begin
         // Quiet SRAM port and no completion unless a state below says so
         r_done       <= 1'b0;
         r_sram_en    <= 1'b0;
         r_sram_we    <= 1'b0;
         r_sram_addr  <= '0;
         r_sram_be    <= 4'h0;
         r_sram_wdata <= '0;

         case (r_state)
            ST_IDLE: begin
               if (req) begin
                  r_sz        <= mem_sz;
                  r_zx        <= mem_sx[2];
                  r_off       <= addr[1:0];
                  r_word0     <= addr[31:2];
                  r_cross     <= w_cross_in;
                  r_be_hi     <= w_be8[7:4];
                  r_wd_hi     <= w_win[63:32];
                  r_sram_en   <= 1'b1;
                  r_sram_addr <= addr[31:2];
                  if (we) begin
                     r_sram_we    <= 1'b1;
                     r_sram_be    <= w_be8[3:0];
                     r_sram_wdata <= w_win[31:0];
                     r_state      <= ST_S0;
                  end else begin
                     r_sram_be <= 4'hF;
                     r_state   <= ST_L0;
                  end
               end
            end

            ST_S0: begin
               if (r_cross) begin
                  r_sram_en    <= 1'b1;
                  r_sram_we    <= 1'b1;
                  r_sram_addr  <= w_word1;
                  r_sram_be    <= r_be_hi;
                  r_sram_wdata <= r_wd_hi;
                  r_state      <= ST_S1;
               end else begin
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end
            end

            ST_S1: begin
               r_done  <= 1'b1;
               r_state <= ST_DONE;
            end

            ST_L0: begin
               if (r_cross) begin
                  r_sram_en   <= 1'b1;
                  r_sram_addr <= w_word1;
                  r_sram_be   <= 4'hF;
                  r_state     <= ST_L1;
               end else begin
                  r_state <= ST_LW;
               end
            end

            ST_L1: begin
               // Word0 read data returns while word1 is being read
               r_w0    <= sram_rdata;
               r_state <= ST_LW;
            end

            ST_LW: begin
               r_rdata <= w_load;
               r_done  <= 1'b1;
               r_state <= ST_DONE;
            end

            ST_DONE: begin
               r_state <= ST_IDLE;
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign rdata      = r_rdata;
   assign busy       = (r_state != ST_IDLE);
   assign done       = r_done;
   assign sram_en    = r_sram_en;
   assign sram_we    = r_sram_we;
   assign sram_addr  = r_sram_addr;
   assign sram_be    = r_sram_be;
   assign sram_wdata = r_sram_wdata;

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

Data-memory responder on the load/store side of the control unit. Accepts one byte/half/word load or store request, built from the control unit's `mem_sz` and `mem_sx` fields, and runs it against a word-wide synchronous SRAM. Misaligned accesses that cross a word boundary are split into two word accesses. Loads return the sign- or zero-extended value with a one-cycle `done` pulse.

## Interface
Parameters:
- none; address 32-bit byte, SRAM 32-bit data, 30-bit word address.

Ports:
- `CLK` in 1: single system clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `req` in 1: request strobe, sampled only in IDLE.
- `we` in 1: 1 = store, 0 = load.
- `mem_sz` in 2: size; 00 byte, 01 half, 10 word, 11 treated as word.
- `mem_sx` in 3: funct3; bit2 = 1 means zero-extend load, 0 means sign-extend.
- `addr` in 32: byte address.
- `wdata` in 32: store data, right-aligned.
- `rdata` out 32: load result, valid from the `done` cycle and held until the next load's `done`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `sram_en` out 1: SRAM access enable.
- `sram_we` out 1: SRAM write enable.
- `sram_addr` out 30: SRAM word address.
- `sram_be` out 4: SRAM byte enables.
- `sram_wdata` out 32: SRAM write data.
- `sram_rdata` in 32: SRAM read data, valid the cycle after the read-enable cycle.

## Operation
**Capture.** In IDLE, `req=1` latches `we`, `mem_sz`, `mem_sx`, `addr`, `wdata`. Inputs are ignored at all other times.

**Derived quantities.**
- Offset o = `addr[1:0]`.
- Word0 = `addr[31:2]`; word1 = word0+1, mod 2^30, so 0x3FFFFFFF wraps to 0.
- Mask: byte 0x01, half 0x03, word 0x0F.
- 8-bit enable = mask<<o; low nibble goes to word0, high nibble to word1.
- Cross = high nibble ≠ 0, i.e. half at o=3, or word at o≠0.

**Write data.** 64-bit window = {32'b0, wdata}<<(8·o). Low half goes to word0, high half to word1.

**Load assembly.** {w1, w0}>>(8·o), then keep 8/16/32 bits and extend per `mem_sx[2]`. For non-crossing loads, w1 = 0.

**States:**
- IDLE: no SRAM activity. On `req`: to S0 if `we`, else L0.
- S0: `sram_en`=1, `sram_we`=1, word0, be = low nibble. Next: S1 if cross, else DONE.
- S1: `sram_en`=1, `sram_we`=1, word1, be = high nibble. Next: DONE.
- L0: `sram_en`=1, `sram_we`=0, word0, be = 0xF. Next: L1 if cross, else LW.
- L1: read word1; capture `sram_rdata` as w0. Next: LW.
- LW: capture `sram_rdata` (w1 if crossing, else w0). Next: DONE.
- DONE: `done`=1; for loads, `rdata` updated (registered, visible this cycle). Next: IDLE.

**Idle outputs.** When `sram_en`=0: `sram_we`=0, `sram_be`=0, `sram_addr`/`sram_wdata` = 0.

**Stores.** Stores never modify `rdata`.

## Timing
Accept edge = T (IDLE with `req`). `done` is high in cycle:
- aligned store: T+2
- crossing store: T+3
- aligned load: T+3
- crossing load: T+4

Other timing rules:
- Back-to-back: new `req` is accepted in the IDLE cycle immediately after DONE. Minimum spacing is one idle cycle.
- `req` held high through an operation is ignored until IDLE, then re-accepted.
- All outputs are registered or decoded from state; no combinational path from `req` to `sram_*`.

**Reset.** `RST` asserted at any time, including mid-split access:
- state goes to IDLE immediately (async);
- `busy`, `done`, `sram_en`, `sram_we` = 0, `sram_be` = 0, `sram_addr` = 0, `sram_wdata` = 0, `rdata` = 0;
- the pending access is abandoned; a partially written word is not rolled back.
- First request is accepted on the first rising edge with `RST` low.

## Test plan
- **Aligned word store/load:** SW 0xDEADBEEF @0x100, then LW @0x100. Store: `sram_addr`=0x40, be=0xF, `done` at T+2. Load: `rdata`=0xDEADBEEF, `done` at T+3.
- **Byte sign/zero extend:** memory word 0x40 = 0x80FF7F01. LB @0x102 gives 0xFFFFFFFF; LBU @0x103 gives 0x00000080; LB @0x100 gives 0x00000001.
- **Crossing half:** SH 0xA1B2 @0x107. S0: addr 0x41, be=0x8, wdata 0xB2000000. S1: addr 0x42, be=0x1, wdata 0x000000A1. LHU @0x107 returns 0x0000A1B2, `done` at T+4.
- **Crossing word with wrap:** SW 0x11223344 @0xFFFFFFFE. Word0 = 0x3FFFFFFF with be=0xC; word1 = 0x0 with be=0x3. LW at the same address returns 0x11223344.
- **Reset mid-operation:** assert `RST` during L1 of a crossing load. Outputs go to 0 the same cycle, `done` never pulses, and the next aligned LW completes normally.
- **Ignored request:** toggle `req` with different `addr` while `busy`. Only the first request's accesses appear on the SRAM port.
